// File: rtl/fix_seq_validator.sv
// fix_seq_validator
// Checks each parsed FIX header against a per-host expected-sequence table
// and emits the new_message/validity/type/connected_host strobe consumed by
// session_manager. The table advances only on session_manager feedback
// (update_seq_i) or on logon sequence resets (seq_reset_i).
module fix_seq_validator #(
  parameter int NUM_HOSTS = 10,
  parameter int HOST_W    = 4,
  parameter int SEQ_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 msg_valid_i,
  output logic                 msg_ready_o,
  input  logic [HOST_W-1:0]    msg_host_i,
  input  logic [SEQ_W-1:0]     msg_seqnum_i,
  input  logic [2:0]           msg_type_i,
  input  logic                 msg_possdup_i,
  input  logic                 checksum_ok_i,
  input  logic                 bodylen_ok_i,
  input  logic                 update_seq_i,
  input  logic [NUM_HOSTS-1:0] update_loc_i,
  input  logic                 seq_reset_i,
  input  logic [NUM_HOSTS-1:0] seq_reset_loc_i,
  output logic                 new_message_o,
  output logic [2:0]           validity_o,
  output logic [2:0]           type_o,
  output logic [NUM_HOSTS-1:0] connected_host_o,
  output logic [SEQ_W-1:0]     expected_seq_o
);

  localparam logic [SEQ_W-1:0] SEQ_ONE = SEQ_W'(1);

  typedef enum logic [1:0] {IDLE, CHECK, EMIT} state_t;

  state_t              state_reg;
  logic [HOST_W-1:0]   host_reg;
  logic [SEQ_W-1:0]    seq_reg;
  logic [2:0]          type_reg;
  logic                possdup_reg;
  logic                csum_ok_reg;
  logic                blen_ok_reg;

  logic [NUM_HOSTS-1:0] host_onehot;
  logic [SEQ_W-1:0]     entry_fwd [NUM_HOSTS];
  logic [SEQ_W-1:0]     fwd_seq;
  logic [2:0]           verdict_next;

  // Per-host expected-sequence entries; the next-state value doubles as the
  // forwarded value so a same-cycle update is visible to the CHECK compare.
  for (genvar gi = 0; gi < NUM_HOSTS; gi++) begin : g_entry
    logic [SEQ_W-1:0] entry_reg;
    logic [SEQ_W-1:0] entry_next;

    // Reset beats update; the counter skips 0 when it wraps.
    always_comb begin
      entry_next = entry_reg;
      if (seq_reset_i && seq_reset_loc_i[gi]) begin
        entry_next = SEQ_ONE;
      end else if (update_seq_i && update_loc_i[gi]) begin
        entry_next = (entry_reg == '1) ? SEQ_ONE : entry_reg + SEQ_ONE;
      end
    end

    // Table storage, all entries restart at sequence 1.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) entry_reg <= SEQ_ONE;
      else      entry_reg <= entry_next;
    end

    assign entry_fwd[gi]   = entry_next;
    assign host_onehot[gi] = (32'(host_reg) == gi);
  end

  // Select the forwarded entry of the captured host (zero if out of range).
  always_comb begin
    fwd_seq = '0;
    for (int i = 0; i < NUM_HOSTS; i++) begin
      if (host_onehot[i]) fwd_seq = fwd_seq | entry_fwd[i];
    end
  end

  // Verdict priority: bad host, checksum, bodylen, gap, fatal low, dup, ok.
  always_comb begin
    verdict_next = 3'd0;
    if (host_onehot == '0)                   verdict_next = 3'd6;
    else if (!csum_ok_reg)                   verdict_next = 3'd1;
    else if (!blen_ok_reg)                   verdict_next = 3'd2;
    else if (seq_reg > fwd_seq)              verdict_next = 3'd3;
    else if (seq_reg < fwd_seq && !possdup_reg) verdict_next = 3'd4;
    else if (seq_reg < fwd_seq)              verdict_next = 3'd5;
  end

  // Accept / check / emit sequencer with registered handshake and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      msg_ready_o      <= 1'b1;
      new_message_o    <= 1'b0;
      validity_o       <= 3'd0;
      type_o           <= 3'd0;
      connected_host_o <= '0;
      expected_seq_o   <= '0;
      host_reg         <= '0;
      seq_reg          <= '0;
      type_reg         <= 3'd0;
      possdup_reg      <= 1'b0;
      csum_ok_reg      <= 1'b0;
      blen_ok_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          new_message_o <= 1'b0;
          if (msg_valid_i) begin
            host_reg    <= msg_host_i;
            seq_reg     <= msg_seqnum_i;
            type_reg    <= msg_type_i;
            possdup_reg <= msg_possdup_i;
            csum_ok_reg <= checksum_ok_i;
            blen_ok_reg <= bodylen_ok_i;
            msg_ready_o <= 1'b0;
            state_reg   <= CHECK;
          end
        end
        CHECK: begin
          validity_o       <= verdict_next;
          type_o           <= type_reg;
          connected_host_o <= host_onehot;
          expected_seq_o   <= fwd_seq;
          new_message_o    <= 1'b1;
          state_reg        <= EMIT;
        end
        EMIT: begin
          new_message_o <= 1'b0;
          msg_ready_o   <= 1'b1;
          state_reg     <= IDLE;
        end
        default: begin
          new_message_o <= 1'b0;
          msg_ready_o   <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fix_seq_validator.sv
// Directed testbench for fix_seq_validator with hand-computed expectations.
module tb_fix_seq_validator;

  logic        clk = 1'b0;
  logic        rst;
  logic        msg_valid_i;
  logic        msg_ready_o;
  logic [3:0]  msg_host_i;
  logic [15:0] msg_seqnum_i;
  logic [2:0]  msg_type_i;
  logic        msg_possdup_i;
  logic        checksum_ok_i;
  logic        bodylen_ok_i;
  logic        update_seq_i;
  logic [9:0]  update_loc_i;
  logic        seq_reset_i;
  logic [9:0]  seq_reset_loc_i;
  logic        new_message_o;
  logic [2:0]  validity_o;
  logic [2:0]  type_o;
  logic [9:0]  connected_host_o;
  logic [15:0] expected_seq_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fix_seq_validator #(.NUM_HOSTS(10), .HOST_W(4), .SEQ_W(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .msg_valid_i      (msg_valid_i),
    .msg_ready_o      (msg_ready_o),
    .msg_host_i       (msg_host_i),
    .msg_seqnum_i     (msg_seqnum_i),
    .msg_type_i       (msg_type_i),
    .msg_possdup_i    (msg_possdup_i),
    .checksum_ok_i    (checksum_ok_i),
    .bodylen_ok_i     (bodylen_ok_i),
    .update_seq_i     (update_seq_i),
    .update_loc_i     (update_loc_i),
    .seq_reset_i      (seq_reset_i),
    .seq_reset_loc_i  (seq_reset_loc_i),
    .new_message_o    (new_message_o),
    .validity_o       (validity_o),
    .type_o           (type_o),
    .connected_host_o (connected_host_o),
    .expected_seq_o   (expected_seq_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One message through accept/check/emit; optional update during CHECK.
  task automatic send(input logic [3:0] h, input logic [15:0] s, input logic [2:0] t,
                      input logic pd, input logic cs, input logic bl,
                      input logic upd_chk, input logic [9:0] upd_loc);
    int w = 0;
    @(negedge clk);
    while (!msg_ready_o && w < 8) begin
      @(negedge clk);
      w++;
    end
    chk("ready_idle", msg_ready_o, 1);
    msg_valid_i   = 1'b1;
    msg_host_i    = h;
    msg_seqnum_i  = s;
    msg_type_i    = t;
    msg_possdup_i = pd;
    checksum_ok_i = cs;
    bodylen_ok_i  = bl;
    @(posedge clk);
    #1;
    msg_valid_i = 1'b0;
    chk("ready_check", msg_ready_o, 0);
    chk("nm_check", new_message_o, 0);
    if (upd_chk) begin
      update_seq_i = 1'b1;
      update_loc_i = upd_loc;
    end
    @(posedge clk);
    #1;
    update_seq_i = 1'b0;
    update_loc_i = '0;
    chk("nm_emit", new_message_o, 1);
    chk("ready_emit", msg_ready_o, 0);
    @(posedge clk);
    #1;
    chk("nm_after", new_message_o, 0);
    $display("msg host=%0d seq=%0h -> validity=%0d type=%0d conn=%b exp=%0h",
             h, s, validity_o, type_o, connected_host_o, expected_seq_o);
  endtask

  task automatic expect_out(input string tag, input logic [2:0] v, input logic [2:0] t,
                            input logic [9:0] conn, input logic [15:0] e);
    chk({tag, "_validity"}, validity_o, v);
    chk({tag, "_type"}, type_o, t);
    chk({tag, "_conn"}, connected_host_o, conn);
    chk({tag, "_expseq"}, expected_seq_o, e);
  endtask

  // Hold table-control inputs for n cycles, then release.
  task automatic pulse(input logic upd, input logic rs, input logic [9:0] uloc,
                       input logic [9:0] rloc, input int n);
    @(negedge clk);
    update_seq_i    = upd;
    update_loc_i    = uloc;
    seq_reset_i     = rs;
    seq_reset_loc_i = rloc;
    repeat (n) @(negedge clk);
    update_seq_i    = 1'b0;
    update_loc_i    = '0;
    seq_reset_i     = 1'b0;
    seq_reset_loc_i = '0;
  endtask

  initial begin
    rst = 1'b0;
    msg_valid_i = 1'b0; msg_host_i = '0; msg_seqnum_i = '0; msg_type_i = '0;
    msg_possdup_i = 1'b0; checksum_ok_i = 1'b1; bodylen_ok_i = 1'b1;
    update_seq_i = 1'b0; update_loc_i = '0; seq_reset_i = 1'b0; seq_reset_loc_i = '0;

    repeat (3) @(negedge clk);
    chk("rst_ready", msg_ready_o, 1);
    chk("rst_nm", new_message_o, 0);
    expect_out("rst", 3'd0, 3'd0, 10'd0, 16'd0);
    rst = 1'b1;

    // in-order message
    send(4'd2, 16'd1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    expect_out("ok", 3'd0, 3'd3, 10'b0000000100, 16'd1);

    // advance host 2 to 2, then gap / fatal low / duplicate
    pulse(1'b1, 1'b0, 10'b0000000100, '0, 1);
    send(4'd2, 16'd5, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    expect_out("gap", 3'd3, 3'd1, 10'b0000000100, 16'd2);
    send(4'd2, 16'd1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    expect_out("low", 3'd4, 3'd2, 10'b0000000100, 16'd2);
    send(4'd2, 16'd1, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    expect_out("dup", 3'd5, 3'd4, 10'b0000000100, 16'd2);
    send(4'd2, 16'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    expect_out("seq0", 3'd4, 3'd0, 10'b0000000100, 16'd2);

    // framing errors and bad host
    send(4'd2, 16'd1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    expect_out("csum", 3'd1, 3'd5, 10'b0000000100, 16'd2);
    send(4'd12, 16'd1, 3'd6, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    expect_out("badhost", 3'd6, 3'd6, 10'd0, 16'd0);

    // update forwarded during CHECK on host 0 (table 1 -> 2)
    send(4'd0, 16'd2, 3'd7, 1'b0, 1'b1, 1'b1, 1'b1, 10'b0000000001);
    expect_out("fwd", 3'd0, 3'd7, 10'b0000000001, 16'd2);

    // loc = 0 is a no-op; multi-bit loc advances hosts 3, 4 and 9
    pulse(1'b1, 1'b0, 10'd0, '0, 1);
    send(4'd3, 16'd1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    expect_out("noop", 3'd0, 3'd1, 10'b0000001000, 16'd1);
    pulse(1'b1, 1'b0, 10'b1000011000, '0, 1);
    send(4'd9, 16'd2, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    expect_out("multi9", 3'd0, 3'd2, 10'b1000000000, 16'd2);
    send(4'd4, 16'd1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    expect_out("multi4", 3'd4, 3'd2, 10'b0000010000, 16'd2);
    send(4'd3, 16'd2, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    expect_out("blen", 3'd2, 3'd3, 10'b0000001000, 16'd2);

    // host 1 to FFFF, then wrap to 1
    pulse(1'b1, 1'b0, 10'b0000000010, '0, 65534);
    send(4'd1, 16'hFFFF, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    expect_out("max", 3'd0, 3'd1, 10'b0000000010, 16'hFFFF);
    pulse(1'b1, 1'b0, 10'b0000000010, '0, 1);
    send(4'd1, 16'd1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    expect_out("wrap", 3'd0, 3'd1, 10'b0000000010, 16'd1);

    // reset beats simultaneous update
    pulse(1'b1, 1'b0, 10'b0000000010, '0, 1);
    pulse(1'b1, 1'b1, 10'b0000000010, 10'b0000000010, 1);
    send(4'd1, 16'd1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    expect_out("rstwin", 3'd0, 3'd2, 10'b0000000010, 16'd1);

    // reset asserted while host 0 message sits in CHECK
    @(negedge clk);
    msg_valid_i = 1'b1; msg_host_i = 4'd0; msg_seqnum_i = 16'd2; msg_type_i = 3'd5;
    @(posedge clk);
    #1;
    msg_valid_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_nm", new_message_o, 0);
    chk("midrst_ready", msg_ready_o, 1);
    expect_out("midrst", 3'd0, 3'd0, 10'd0, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("postrst_nm", new_message_o, 0);
    end
    for (int h = 0; h < 10; h++) begin
      send(4'(h), 16'd1, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
      expect_out("tbl1", 3'd0, 3'd0, 10'(1 << h), 16'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
